// File: rtl/sc_transition_pkg.sv
// Shared state encoding and width constants for the screen-transition sequencer
// and the game-control FSM that drives it.
package sc_transition_pkg;

  localparam int SC_STATE_W        = 3;
  localparam int SC_DEF_STEP_WIDTH = 4;

  typedef enum logic [SC_STATE_W-1:0] {
    SC_IDLE     = 3'd0,
    SC_FADE_OUT = 3'd1,
    SC_HOLD     = 3'd2,
    SC_FADE_IN  = 3'd3,
    SC_DONE     = 3'd4
  } sc_state_e;

  // States in which the timer counter runs and eoc pulses are consumed.
  function automatic logic sc_is_phase(input sc_state_e s);
    return (s == SC_FADE_OUT) || (s == SC_HOLD) || (s == SC_FADE_IN);
  endfunction

endpackage

// File: rtl/sc_transition_step_counter.sv
// Counts accepted eoc events up to a per-phase terminal value; term is a same-cycle flag
// on the event that reaches it, after which the count self-clears. No backpressure.
module sc_transition_step_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] term_val,
  output logic             term
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    term  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == term_val - WIDTH'(1)) begin
        term  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sc_transition_sequencer.sv
// Fade-out / blanked hold / fade-in sequencer paced by the timer's eoc pulse; all outputs
// registered, one cycle after the deciding edge. start is only honoured in IDLE, never queued.
module sc_transition_sequencer
  import sc_transition_pkg::*;
#(
  parameter int FADE_STEPS = 8,
  parameter int HOLD_TICKS = 4,
  parameter int STEP_WIDTH = SC_DEF_STEP_WIDTH
) (
  input  logic                  SC_TRANSEQ_CLOCK_50,
  input  logic                  SC_TRANSEQ_RESET_InLow,
  input  logic                  SC_TRANSEQ_start_InLow,
  input  logic                  SC_TRANSEQ_eoc_InLow,
  output logic                  SC_TRANSEQ_count_OutLow,
  output logic                  SC_TRANSEQ_busy_OutLow,
  output logic                  SC_TRANSEQ_blank_OutLow,
  output logic                  SC_TRANSEQ_swap_OutLow,
  output logic                  SC_TRANSEQ_done_OutLow,
  output logic [STEP_WIDTH-1:0] SC_TRANSEQ_brightness
);

  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int CNT_W  = (HOLD_W > STEP_WIDTH) ? HOLD_W : STEP_WIDTH;
  localparam logic [STEP_WIDTH-1:0] FULL = STEP_WIDTH'(FADE_STEPS);

  sc_state_e             state_q, state_d;
  logic                  restart_q, restart_d;
  logic                  count_q, count_d;
  logic                  busy_q, busy_d;
  logic                  blank_q, blank_d;
  logic                  swap_q, swap_d;
  logic                  done_q, done_d;
  logic [STEP_WIDTH-1:0] bright_q, bright_d;

  logic                  eoc_acc;
  logic                  step_clr;
  logic                  step_term;
  logic [CNT_W-1:0]      step_term_val;

  // The restart cycle lets the timer clear, so any eoc landing in it is stale.
  assign eoc_acc  = !SC_TRANSEQ_eoc_InLow && !restart_q && sc_is_phase(state_q);
  assign step_clr = restart_q || !sc_is_phase(state_q);

  always_comb begin
    step_term_val = CNT_W'(FADE_STEPS);
    if (state_q == SC_HOLD) step_term_val = CNT_W'(HOLD_TICKS);
  end

  sc_transition_step_counter #(
    .WIDTH(CNT_W)
  ) u_step_counter (
    .clk      (SC_TRANSEQ_CLOCK_50),
    .rst_n    (SC_TRANSEQ_RESET_InLow),
    .clr      (step_clr),
    .inc      (eoc_acc),
    .term_val (step_term_val),
    .term     (step_term)
  );

  always_comb begin
    state_d  = state_q;
    bright_d = bright_q;
    case (state_q)
      SC_IDLE: begin
        if (!SC_TRANSEQ_start_InLow) state_d = SC_FADE_OUT;
      end
      SC_FADE_OUT: begin
        if (eoc_acc && (bright_q != '0)) bright_d = bright_q - STEP_WIDTH'(1);
        if (step_term) state_d = SC_HOLD;
      end
      SC_HOLD: begin
        if (step_term) state_d = SC_FADE_IN;
      end
      SC_FADE_IN: begin
        if (eoc_acc && (bright_q != FULL)) bright_d = bright_q + STEP_WIDTH'(1);
        if (step_term) state_d = SC_DONE;
      end
      SC_DONE:  state_d = SC_IDLE;
      default:  state_d = SC_IDLE;
    endcase

    restart_d = sc_is_phase(state_d) && (state_d != state_q);
    count_d   = !(sc_is_phase(state_d) && !restart_d);
    busy_d    = (state_d == SC_IDLE);
    blank_d   = (state_d != SC_HOLD);
    swap_d    = !((state_d == SC_HOLD) && (state_q != SC_HOLD));
    done_d    = (state_d != SC_DONE);
  end

  always_ff @(posedge SC_TRANSEQ_CLOCK_50 or negedge SC_TRANSEQ_RESET_InLow) begin
    if (!SC_TRANSEQ_RESET_InLow) begin
      state_q   <= SC_IDLE;
      restart_q <= 1'b0;
      count_q   <= 1'b1;
      busy_q    <= 1'b1;
      blank_q   <= 1'b1;
      swap_q    <= 1'b1;
      done_q    <= 1'b1;
      bright_q  <= FULL;
    end else begin
      state_q   <= state_d;
      restart_q <= restart_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      blank_q   <= blank_d;
      swap_q    <= swap_d;
      done_q    <= done_d;
      bright_q  <= bright_d;
    end
  end

  assign SC_TRANSEQ_count_OutLow = count_q;
  assign SC_TRANSEQ_busy_OutLow  = busy_q;
  assign SC_TRANSEQ_blank_OutLow = blank_q;
  assign SC_TRANSEQ_swap_OutLow  = swap_q;
  assign SC_TRANSEQ_done_OutLow  = done_q;
  assign SC_TRANSEQ_brightness   = bright_q;

endmodule
